// File: rtl/glitch_monitor_if.sv
// Bundle between a glitch_monitor and the bench that drives it: the stimulus and
// response being watched, plus the per-window result and running counters.
interface glitch_monitor_if #(
    parameter int CNT_W = 8
);
    logic [3:0]       stim_i;
    logic             y_i;
    logic             result_valid;
    logic             result_y;
    logic [1:0]       result_trans;
    logic             glitch_o;
    logic             busy;
    logic [CNT_W-1:0] glitch_count;
    logic [CNT_W-1:0] vector_count;

    // master: stimulus source / result consumer
    modport master (
        output stim_i,
        output y_i,
        input  result_valid,
        input  result_y,
        input  result_trans,
        input  glitch_o,
        input  busy,
        input  glitch_count,
        input  vector_count
    );

    // slave: the monitor itself
    modport slave (
        input  stim_i,
        input  y_i,
        output result_valid,
        output result_y,
        output result_trans,
        output glitch_o,
        output busy,
        output glitch_count,
        output vector_count
    );
endinterface

// File: rtl/glitch_monitor.sv
// Oversampling hazard checker: after each stimulus change, counts response
// transitions over a fixed window and reports settled value, count and glitch flag.
module glitch_monitor #(
    parameter int SETTLE_CYCLES = 8,
    parameter int CNT_W         = 8
) (
    input logic             clk,
    input logic             rst,
    glitch_monitor_if.slave mon
);
    localparam int TW = $clog2(SETTLE_CYCLES);
    localparam logic [TW-1:0] TIMER_LAST = TW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t           state_q;
    logic [3:0]       stim_meta_q, stim_s_q, stim_prev_q;
    logic             y_meta_q, y_s_q, y_prev_q;
    logic [TW-1:0]    timer_q;
    logic [1:0]       trans_q;
    logic             result_valid_q, result_y_q, glitch_q, busy_q;
    logic [1:0]       result_trans_q;
    logic [CNT_W-1:0] glitch_count_q, vector_count_q;

    logic             chg, ytog;
    logic [1:0]       trans_d;
    logic             glitch_d;
    logic [CNT_W-1:0] vector_count_d;

    assign chg  = (stim_s_q != stim_prev_q);
    assign ytog = (y_s_q != y_prev_q);

    // Transition count including this cycle's toggle, saturating at 3
    always_comb begin
        trans_d = trans_q;
        if (ytog && trans_q != 2'd3) begin
            trans_d = trans_q + 2'd1;
        end
    end

    assign glitch_d       = (trans_d >= 2'd2);
    assign vector_count_d = vector_count_q + CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            stim_meta_q    <= '0;
            stim_s_q       <= '0;
            stim_prev_q    <= '0;
            y_meta_q       <= 1'b0;
            y_s_q          <= 1'b0;
            y_prev_q       <= 1'b0;
            timer_q        <= '0;
            trans_q        <= '0;
            result_valid_q <= 1'b0;
            result_y_q     <= 1'b0;
            result_trans_q <= '0;
            glitch_q       <= 1'b0;
            busy_q         <= 1'b0;
            glitch_count_q <= '0;
            vector_count_q <= '0;
        end else begin
            stim_meta_q <= mon.stim_i;
            stim_s_q    <= stim_meta_q;
            stim_prev_q <= stim_s_q;
            y_meta_q    <= mon.y_i;
            y_s_q       <= y_meta_q;
            y_prev_q    <= y_s_q;

            result_valid_q <= 1'b0;
            glitch_q       <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (chg) begin
                        state_q        <= SETTLE;
                        busy_q         <= 1'b1;
                        timer_q        <= '0;
                        trans_q        <= {1'b0, ytog};
                        vector_count_q <= vector_count_d;
                    end
                end

                SETTLE: begin
                    if (chg) begin
                        // Abandon the current window silently and start over
                        timer_q        <= '0;
                        trans_q        <= {1'b0, ytog};
                        vector_count_q <= vector_count_d;
                    end else begin
                        trans_q <= trans_d;
                        if (timer_q == TIMER_LAST) begin
                            state_q        <= REPORT;
                            result_valid_q <= 1'b1;
                            result_y_q     <= y_s_q;
                            result_trans_q <= trans_d;
                            glitch_q       <= glitch_d;
                        end else begin
                            timer_q <= timer_q + TW'(1);
                        end
                    end
                end

                REPORT: begin
                    if (glitch_q && glitch_count_q != {CNT_W{1'b1}}) begin
                        glitch_count_q <= glitch_count_q + CNT_W'(1);
                    end
                    if (chg) begin
                        state_q        <= SETTLE;
                        timer_q        <= '0;
                        trans_q        <= {1'b0, ytog};
                        vector_count_q <= vector_count_d;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign mon.result_valid = result_valid_q;
    assign mon.result_y     = result_y_q;
    assign mon.result_trans = result_trans_q;
    assign mon.glitch_o     = glitch_q;
    assign mon.busy         = busy_q;
    assign mon.glitch_count = glitch_count_q;
    assign mon.vector_count = vector_count_q;
endmodule

// File: tb/tb_glitch_monitor.sv
// Directed bench for glitch_monitor: table of single-window vectors, then restart,
// report-with-change, counter saturation (CNT_W=2 twin) and mid-window reset.
module tb_glitch_monitor;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] stim = 4'd0;
    logic       y = 1'b0;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    glitch_monitor_if #(.CNT_W(8)) if8 ();
    glitch_monitor_if #(.CNT_W(2)) if2 ();

    assign if8.stim_i = stim;
    assign if8.y_i    = y;
    assign if2.stim_i = stim;
    assign if2.y_i    = y;

    glitch_monitor #(.SETTLE_CYCLES(8), .CNT_W(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .mon (if8)
    );

    glitch_monitor #(.SETTLE_CYCLES(8), .CNT_W(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .mon (if2)
    );

    typedef struct {
        logic [3:0]  stim;
        logic [15:0] pat;      // bit j = y_i value first seen at edge k+j
        logic        exp_y;
        logic [1:0]  exp_trans;
        logic        exp_glitch;
        int          exp_vcnt;
        int          exp_gcnt;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at a drive point (#1 after a rising edge). Cycle j: drive, then sample
    // on the falling edge. Edge k is the edge right after the j=0 drive.
    task automatic run(input logic [3:0] s0, input logic [3:0] s1, input int j1,
                       input logic [31:0] pat, input int ncyc,
                       output int nv, output int fj, output int lj,
                       output int ry, output int rt, output int rg,
                       output int stray, output int busy5, output int busy_end);
        nv = 0; fj = -1; lj = -1; ry = -1; rt = -1; rg = -1;
        stray = 0; busy5 = -1; busy_end = -1;
        for (int j = 0; j < ncyc; j++) begin
            if (j == 0)  stim = s0;
            if (j == j1) stim = s1;
            y = pat[j];
            @(negedge clk);
            if (if8.result_valid) begin
                nv++;
                if (nv == 1) begin
                    fj = j;
                    ry = int'(if8.result_y);
                    rt = int'(if8.result_trans);
                    rg = int'(if8.glitch_o);
                end
                lj = j;
            end
            if (if8.glitch_o && !if8.result_valid) stray++;
            if (j == 5) busy5 = int'(if8.busy);
            if (j == ncyc - 1) busy_end = int'(if8.busy);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int nv, fj, lj, ry, rt, rg, stray, b5, be;

        vecs[0] = '{4'b1000, 16'hFFF8, 1'b1, 2'd1, 1'b0, 1, 0};  // y rises at k+3
        vecs[1] = '{4'b0100, 16'h0000, 1'b0, 2'd1, 1'b0, 2, 0};  // toggle coincident with change
        vecs[2] = '{4'b0110, 16'h0018, 1'b0, 2'd2, 1'b1, 3, 1};  // 2-cycle pulse
        vecs[3] = '{4'b0011, 16'hFFFF, 1'b1, 2'd1, 1'b0, 4, 1};
        vecs[4] = '{4'b0001, 16'hFFFF, 1'b1, 2'd0, 1'b0, 5, 1};  // y constant 1
        vecs[5] = '{4'b1001, 16'h002B, 1'b0, 2'd3, 1'b1, 6, 2};  // 5 toggles, saturates
        vecs[6] = '{4'b1011, 16'hFE00, 1'b0, 2'd0, 1'b0, 7, 2};  // toggle just after window
        vecs[7] = '{4'b1111, 16'h00FF, 1'b0, 2'd1, 1'b0, 8, 2};  // toggle in last counted slot
        vecs[8] = '{4'b1110, 16'h00FE, 1'b0, 2'd2, 1'b1, 9, 3};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_valid",  int'(if8.result_valid), 0);
        check("reset_y",      int'(if8.result_y), 0);
        check("reset_trans",  int'(if8.result_trans), 0);
        check("reset_glitch", int'(if8.glitch_o), 0);
        check("reset_busy",   int'(if8.busy), 0);
        check("reset_gcnt",   int'(if8.glitch_count), 0);
        check("reset_vcnt",   int'(if8.vector_count), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run(vecs[i].stim, 4'd0, -1, {{16{vecs[i].pat[15]}}, vecs[i].pat}, 16,
                nv, fj, lj, ry, rt, rg, stray, b5, be);
            $display("vec %0d stim=%b pat=%h: valid=%0d@%0d y=%0d trans=%0d glitch=%0d vcnt=%0d gcnt=%0d",
                     i, vecs[i].stim, vecs[i].pat, nv, fj, ry, rt, rg,
                     if8.vector_count, if8.glitch_count);
            check($sformatf("v%0d_nvalid", i), nv, 1);
            check($sformatf("v%0d_latency", i), fj, 11);
            check($sformatf("v%0d_y", i), ry, int'(vecs[i].exp_y));
            check($sformatf("v%0d_trans", i), rt, int'(vecs[i].exp_trans));
            check($sformatf("v%0d_glitch", i), rg, int'(vecs[i].exp_glitch));
            check($sformatf("v%0d_stray_glitch", i), stray, 0);
            check($sformatf("v%0d_busy_mid", i), b5, 1);
            check($sformatf("v%0d_busy_end", i), be, 0);
            check($sformatf("v%0d_vcnt", i), int'(if8.vector_count), vecs[i].exp_vcnt);
            check($sformatf("v%0d_gcnt", i), int'(if8.glitch_count), vecs[i].exp_gcnt);
        end
        check("w2_vcnt_wrap", int'(if2.vector_count), 1);
        check("w2_gcnt", int'(if2.glitch_count), 3);

        // Second change while timer=4: only the restarted window reports
        run(4'b0101, 4'b0100, 5, 32'h0, 24, nv, fj, lj, ry, rt, rg, stray, b5, be);
        $display("restart: valid=%0d first@%0d last@%0d trans=%0d vcnt=%0d",
                 nv, fj, lj, rt, if8.vector_count);
        check("restart_nvalid", nv, 1);
        check("restart_latency", fj, 16);
        check("restart_trans", rt, 0);
        check("restart_vcnt", int'(if8.vector_count), 11);

        // Change lands in the REPORT cycle: report kept, new window follows directly
        run(4'b0001, 4'b0011, 9, 32'h0000_000C, 32, nv, fj, lj, ry, rt, rg, stray, b5, be);
        $display("report_chg: valid=%0d first@%0d last@%0d trans=%0d glitch=%0d vcnt=%0d gcnt8=%0d gcnt2=%0d",
                 nv, fj, lj, rt, rg, if8.vector_count, if8.glitch_count, if2.glitch_count);
        check("rptchg_nvalid", nv, 2);
        check("rptchg_first", fj, 11);
        check("rptchg_last", lj, 20);
        check("rptchg_trans", rt, 2);
        check("rptchg_glitch", rg, 1);
        check("rptchg_vcnt", int'(if8.vector_count), 13);
        check("rptchg_gcnt8", int'(if8.glitch_count), 4);
        check("w2_gcnt_sat", int'(if2.glitch_count), 3);

        // Reset asserted with timer=5
        stim = 4'b1010;
        for (int j = 0; j < 8; j++) begin
            @(posedge clk);
            #1;
        end
        check("prerst_busy", int'(if8.busy), 1);
        rst  = 1'b1;
        stim = 4'd0;
        #1;
        $display("reset mid-window: valid=%0d busy=%0d vcnt=%0d gcnt=%0d",
                 if8.result_valid, if8.busy, if8.vector_count, if8.glitch_count);
        check("midrst_valid",  int'(if8.result_valid), 0);
        check("midrst_y",      int'(if8.result_y), 0);
        check("midrst_trans",  int'(if8.result_trans), 0);
        check("midrst_glitch", int'(if8.glitch_o), 0);
        check("midrst_busy",   int'(if8.busy), 0);
        check("midrst_gcnt",   int'(if8.glitch_count), 0);
        check("midrst_vcnt",   int'(if8.vector_count), 0);
        check("midrst_gcnt2",  int'(if2.glitch_count), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        run(4'd0, 4'd0, -1, 32'h0, 16, nv, fj, lj, ry, rt, rg, stray, b5, be);
        $display("post-reset quiet: valid=%0d busy=%0d vcnt=%0d", nv, be, if8.vector_count);
        check("postrst_nvalid", nv, 0);
        check("postrst_busy", be, 0);
        check("postrst_vcnt", int'(if8.vector_count), 0);

        run(4'b0011, 4'd0, -1, 32'hFFFF_FFF0, 16, nv, fj, lj, ry, rt, rg, stray, b5, be);
        $display("clean window: valid=%0d@%0d y=%0d trans=%0d vcnt=%0d gcnt=%0d",
                 nv, fj, ry, rt, if8.vector_count, if8.glitch_count);
        check("clean_nvalid", nv, 1);
        check("clean_latency", fj, 11);
        check("clean_y", ry, 1);
        check("clean_trans", rt, 1);
        check("clean_vcnt", int'(if8.vector_count), 1);
        check("clean_gcnt", int'(if8.glitch_count), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/glitch_monitor.md
# glitch_monitor

Oversampling response checker for the combinational glitch-simulation benches. It watches a 4-bit stimulus vector (a, b, c, d) and the single-bit response y of the combinational block under test. After every stimulus change it counts y transitions over a fixed settle window and reports the settled value, the transition count and a glitch flag; two or more transitions in one window is a glitch. It lets the bench (FPGA or simulation) detect hazards without reading waveforms by eye.

## Interface
- SETTLE_CYCLES, 8: length of the observation window in clk cycles; must be ≥ 2.
- CNT_W, 8: width of the glitch_count and vector_count counters.

- clk  in  1  sampling clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- stim_i  in  4  stimulus {a,b,c,d}; asynchronous to clk.
- y_i  in  1  response of the block under test; asynchronous to clk.
- result_valid  out  1  single-cycle pulse; result fields are valid.
- result_y  out  1  y value at the end of the window.
- result_trans  out  2  y transitions in the window; saturates at 3.
- glitch_o  out  1  equals result_valid AND (result_trans ≥ 2).
- busy  out  1  high while a window is open (SETTLE or REPORT).
- glitch_count  out  CNT_W  number of glitching windows; saturates at all-ones.
- vector_count  out  CNT_W  number of detected stimulus changes; wraps modulo 2^CNT_W.

## Operation
- Synchronisation
  - stim_i and y_i each pass through a 2-flop synchroniser, producing stim_s and y_s.
  - stim_prev and y_prev are stim_s and y_s delayed by one cycle.
  - chg = (stim_s != stim_prev); ytog = (y_s != y_prev).
- FSM states: IDLE, SETTLE, REPORT.
- IDLE
  - If chg: go to SETTLE, timer←0, trans←ytog, vector_count++.
  - A y toggle coincident with the stimulus change counts as a transition.
- SETTLE
  - If chg (new stimulus mid-window): restart the window. timer←0, trans←ytog, vector_count++. No report is emitted for the abandoned window.
  - Else, if ytog: trans←min(trans+1, 3).
  - Else, if timer == SETTLE_CYCLES−1: go to REPORT and latch result_y←y_s. A ytog in this same cycle is counted before latching.
  - Otherwise: timer++.
- REPORT (exactly one cycle)
  - result_valid=1, result_trans=trans, glitch_o=(trans≥2).
  - If glitch_o: glitch_count increments, saturating.
  - If chg in this cycle: the report is still emitted, then go directly to SETTLE with a new window (timer←0, trans←ytog, vector_count++).
  - Otherwise: go to IDLE.
- y toggles while in IDLE, outside any window, are ignored.
- Reset
  - All flops clear: synchronisers 0, state IDLE, timer/trans 0, both counters 0.
  - Outputs at reset: result_valid=0, result_y=0, result_trans=0, glitch_o=0, busy=0, glitch_count=0, vector_count=0.
  - Reset mid-window abandons the window; no report is emitted.
  - After reset release, stim_s=0, so a nonzero stim_i registers as a change.

## Timing
- Edge k is the first rising edge at which stim_i holds its new value.
  - stim_s updates at edge k+1.
  - chg is high in the cycle following edge k+1.
  - SETTLE is entered at edge k+2.
- REPORT is entered at edge k+2+SETTLE_CYCLES. result_valid is high for the single cycle after that edge.
- Minimum window-to-window spacing is SETTLE_CYCLES+1 cycles. Faster stimulus causes restarts, not reports.
- result_y, result_trans, glitch_count and vector_count hold their values between reports.
- result_trans and glitch_o are meaningful only while result_valid=1. glitch_o is 0 at all other times.
- busy is high from the edge entering SETTLE through the REPORT cycle.

## Test plan
- SETTLE_CYCLES=8. stim 0000→1000 with y 0→1 at edge k+3 → result_valid in the single cycle after edge k+10; result_y=1, result_trans=1, glitch_o=0, vector_count=1.
- stim change with y pulsing 0→1→0 (2 cycles high) inside the window → result_trans=2, glitch_o=1, result_y=0, glitch_count=1.
- stim change with y constant 1 → result_trans=0, glitch_o=0, result_y=1.
- Second stim change at timer=4 → exactly one result_valid, for the second vector; vector_count increases by 2.
- y toggling 5 times in one window → result_trans=3. With CNT_W=2, four glitching windows → glitch_count=3, which then holds.
- rst pulse at timer=5 → every output reads 0 within the reset; no result_valid follows; the next stim change starts a clean window.
